// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer.
//   - state_t : 1-bit run/idle state encoding (ST_IDLE=0, ST_RUN=1)
//   - MAX_CNT_WIDTH / CNT_ZERO_MAX : all-zero count constant; a module of
//     width W takes CNT_ZERO_MAX[W-1:0] as its own zero count.
package countdown_timer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int unsigned MAX_CNT_WIDTH = 64;
  localparam logic [MAX_CNT_WIDTH-1:0] CNT_ZERO_MAX = '0;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with a run/idle FSM, one-shot or auto-reload mode
// and a single-cycle done pulse at terminal count.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   synchronous active-high reset (overrides everything)
//   start   in   capture period and begin (or restart) counting
//   abort   in   stop counting, return to idle, no done
//   reload  in   1 = auto-reload on expiry, 0 = one-shot (sampled at expiry)
//   en      in   count enable
//   period  in   [width] terminal count, captured on start
//   cnt     out  [width] remaining count (registered)
//   busy    out  1 while in RUN; it is the state register itself, so it also
//                serves as the FSM state observation point
//   done    out  one-cycle pulse after an expiry edge (registered)
//
// Control handshake: start/abort/en are level-sampled on every rising edge;
// there is no ready/back-pressure. Priority is rst > abort > start > en.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             reload,
  input  logic             en,
  input  logic [width-1:0] period,
  output logic [width-1:0] cnt,
  output logic             busy,
  output logic             done
);

  localparam logic [width-1:0] CNT_ZERO = CNT_ZERO_MAX[width-1:0];
  localparam logic [width-1:0] CNT_ONE  = width'(1);

  state_t           state, state_n;
  logic [width-1:0] cnt_n;
  logic [width-1:0] period_q, period_n;
  logic             done_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= CNT_ZERO;
      period_q <= CNT_ZERO;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      period_q <= period_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    period_n = period_q;
    done_n   = 1'b0;

    if (abort) begin
      // Abort from either state clears the count and never pulses done.
      state_n = ST_IDLE;
      cnt_n   = CNT_ZERO;
    end else if (start) begin
      // Start wins over a simultaneous expiry: the old count is discarded.
      period_n = period;
      cnt_n    = period;
      if (period != CNT_ZERO) begin
        state_n = ST_RUN;
      end else begin
        // Zero period expires immediately without ever entering RUN.
        state_n = ST_IDLE;
        done_n  = 1'b1;
      end
    end else if (state == ST_RUN && en) begin
      if (cnt == CNT_ONE) begin
        done_n = 1'b1;
        if (reload) begin
          cnt_n = period_q;
        end else begin
          cnt_n   = CNT_ZERO;
          state_n = ST_IDLE;
        end
      end else begin
        cnt_n = cnt - CNT_ONE;
      end
    end
  end

  assign busy = (state == ST_RUN);

endmodule

// File: tb/tb_countdown_timer.sv
module tb_countdown_timer;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst, start, abort, reload, en;
  logic [W-1:0] period;
  logic [W-1:0] cnt;
  logic         busy, done;

  always #5 clk = ~clk;

  countdown_timer #(.width(W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .reload(reload),
    .en(en), .period(period), .cnt(cnt), .busy(busy), .done(done)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // Behavioural view: a timer holds "remaining" enabled cycles and a running
  // flag; each enabled cycle consumes one, and reaching zero is an expiry.
  int m_cnt = 0;
  int m_per = 0;
  bit m_run = 0;
  bit m_done = 0;

  function automatic void model_update(bit i_rst, bit i_start, bit i_abort,
                                       bit i_reload, bit i_en, int i_per);
    m_done = 0;
    if (i_rst) begin
      m_cnt = 0; m_per = 0; m_run = 0;
    end else if (i_abort) begin
      m_cnt = 0; m_run = 0;
    end else if (i_start) begin
      m_per  = i_per;
      m_cnt  = i_per;
      m_run  = (i_per > 0);
      m_done = (i_per == 0);
    end else if (m_run && i_en) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        m_done = 1;
        if (i_reload) m_cnt = m_per;
        else m_run = 0;
      end
    end
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  // ---------------- driver ----------------
  // Drive inputs, clock one edge, advance the model, sample #1 after the edge.
  task automatic step(input bit i_rst, input bit i_start, input bit i_abort,
                      input bit i_reload, input bit i_en, input int i_per,
                      input string tag);
    rst = i_rst; start = i_start; abort = i_abort;
    reload = i_reload; en = i_en; period = W'(i_per);
    @(posedge clk);
    model_update(i_rst, i_start, i_abort, i_reload, i_en, i_per);
    #1;
    chk({tag, ".cnt"},  int'(cnt),  m_cnt);
    chk({tag, ".busy"}, int'(busy), int'(m_run));
    chk({tag, ".done"}, int'(done), int'(m_done));
    // Invariants that hold for any input sequence.
    chk({tag, ".busy_nz"}, int'(busy && cnt == '0), 0);
    chk({tag, ".done_busy"}, int'(done && busy && !reload), 0);
  endtask

  task automatic idle_cycle(input string tag);
    step(0, 0, 0, 0, 0, 0, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat;
    int en_pat[5];
    rst = 1; start = 0; abort = 0; reload = 0; en = 0; period = '0;

    // Reset with other inputs active
    step(1, 1, 0, 1, 1, 7, "reset0");
    step(1, 0, 0, 0, 1, 0, "reset1");
    chk("reset_cnt", int'(cnt), 0);

    // One-shot, period=5
    step(0, 1, 0, 0, 1, 5, "os_start");
    chk("os_load", int'(cnt), 5);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 5, "os_run");
    chk("os_done_lit", int'(done), 1);
    chk("os_cnt0_lit", int'(cnt), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, "os_after");

    // Gated enable, period=3
    step(0, 1, 0, 0, 0, 3, "gate_start");
    en_pat = '{1, 0, 1, 0, 1};
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, en_pat[i][0], 0, "gate_run");
    chk("gate_done_lit", int'(done), 1);

    // Auto-reload, period=2, then drop reload
    step(0, 1, 0, 1, 0, 2, "ar_start");
    for (int i = 0; i < 7; i++) step(0, 0, 0, 1, 1, 0, "ar_run");
    chk("ar_busy_lit", int'(busy), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, "ar_stop");
    chk("ar_idle_lit", int'(busy), 0);

    // Restart/abort collision
    step(0, 1, 0, 0, 0, 4, "col_start");
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, "col_run");
    chk("col_at1", int'(cnt), 1);
    step(0, 1, 0, 0, 1, 9, "col_restart");
    chk("col_restart_cnt", int'(cnt), 9);
    chk("col_restart_nodone", int'(done), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, "col_run2");
    step(0, 1, 1, 0, 1, 9, "col_abort");
    chk("col_abort_cnt", int'(cnt), 0);

    // Edge periods
    step(0, 1, 0, 0, 1, 0, "p0_start");
    chk("p0_done_lit", int'(done), 1);
    idle_cycle("p0_after");
    step(0, 1, 0, 0, 1, 1, "p1_start");
    step(0, 0, 0, 0, 1, 0, "p1_run");
    chk("p1_done_lit", int'(done), 1);
    step(0, 1, 0, 0, 1, 255, "p255_start");
    lat = 0;
    while (!done && lat < 300) begin
      step(0, 0, 0, 0, 1, 0, "p255_run");
      lat++;
    end
    chk("p255_latency", lat, 255);

    // Reset mid-operation, then a fresh one-shot
    step(0, 1, 0, 0, 0, 5, "rm_start");
    step(0, 0, 0, 0, 1, 0, "rm_run");
    step(0, 0, 0, 0, 1, 0, "rm_run");
    chk("rm_at3", int'(cnt), 3);
    step(1, 1, 0, 0, 1, 5, "rm_reset");
    step(0, 1, 0, 0, 1, 5, "rm_os_start");
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 0, "rm_os_run");

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int p;
      case ($urandom_range(0, 7))
        0:       p = 0;
        1:       p = 1;
        2:       p = 255;
        default: p = $urandom_range(0, 12);
      endcase
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 11) == 0,
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) != 0,
           p, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable down-counter with run/idle FSM, one-shot or auto-reload mode, and a single-cycle `done` pulse at terminal count.
- Complements the existing free-running enable up-counter. Used wherever a block must wait a programmed number of enabled cycles: timeouts, baud ticks, pacing strobes.
- Sits between a control/CSR block, which issues `start` and `period`, and a consumer that reacts to `done`.

Parameters:
- width, 8, bit width of the count and the period value; must be >= 1.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  load `period` and begin counting; also restarts a running count.
- abort  in  1  stop counting immediately and return to IDLE without `done`.
- reload  in  1  mode: 1 = auto-reload on expiry, 0 = one-shot. Sampled at the expiry cycle.
- en  in  1  count enable; the count decrements only on cycles where en=1.
- period  in  width  unsigned terminal count, captured on `start`.
- cnt  out  width  current remaining count (registered).
- busy  out  1  1 while the FSM is in RUN (registered).
- done  out  1  one-cycle pulse on expiry (registered).

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, cnt=0, period_q=0, busy=0, done=0. rst overrides every other input. Reset mid-count discards the count and produces no `done`.
- Input priority within a cycle: rst > abort > start > en-count.
- `done` defaults to 0 every cycle. It is 1 only in the cycle after an expiry edge, as defined below.
- State IDLE:
  - start=1: period_q<=period and cnt<=period.
    - period!=0: state<=RUN, busy<=1.
    - period==0: stay IDLE, cnt<=0, done<=1 (immediate expiry, no RUN cycle).
  - en has no effect; cnt holds its value (0 after a one-shot expiry).
  - abort in IDLE: cnt<=0, no other effect.
- State RUN:
  - abort=1: state<=IDLE, busy<=0, cnt<=0, done stays 0.
  - start=1 (no abort): period_q<=period, cnt<=period. No `done`, even if cnt was 1 with en=1 in the same cycle. A period of 0 takes the IDLE/period==0 path above: done<=1, state<=IDLE.
  - en=1, cnt>1: cnt<=cnt-1.
  - en=1, cnt==1 (expiry): done<=1.
    - reload=1: cnt<=period_q, stay RUN. A period_q of 1 therefore expires on every enabled cycle.
    - reload=0: cnt<=0, state<=IDLE, busy<=0.
  - en=0: hold all state.
- Latency: start at edge E0 with period=P>0 and en held at 1 gives cnt=P after E0, cnt=1 after E0+(P-1), and done=1 for exactly the cycle after edge E0+P. Equivalently, done rises P cycles after busy rises.
- Arithmetic: unsigned modulo-2^width. cnt never decrements below 0 because RUN is never entered or kept with cnt==0, so no underflow path exists. period=2^width-1 is legal.
- The `period` input is ignored except on `start`. Changing it mid-run has no effect until the next `start`. Auto-reload uses period_q.
- busy==1 implies cnt!=0. Invariant for assertions: done=1 and busy=1 together only in auto-reload mode.

Decomposition:
- Shared package `countdown_timer_pkg`: 1-bit state encoding with constants ST_IDLE=0 and ST_RUN=1, plus a helper constant for the all-zero count of a given width.
- Single module; no sub-module. The decrement/compare is trivial.
- Optional: a 1-cycle `done`-to-level stretcher is left to consumers.

Test Plan:
- One-shot: width=8, period=5, en=1, reload=0, start pulse → cnt 5,4,3,2,1,0; done high 1 cycle as cnt becomes 0; busy 1 for 5 cycles then 0; en pulses afterward leave cnt=0.
- Gated enable: period=3, en toggled 1,0,1,0,1 → cnt 3,2,2,1,1,0; done only on the final transition; total 5 cycles from first count.
- Auto-reload: period=2, reload=1, en=1 for 7 cycles → cnt 2,1,2,1,2,1,2; done on every reload (cycles 2,4,6); busy stays 1. Then drop reload at the next expiry → IDLE, cnt=0.
- Restart/abort collision: period=4 running at cnt=1 with en=1; assert start with period=9 → cnt=9, no done. Later assert abort and start together at cnt=6 → IDLE, cnt=0, busy=0, no done.
- Edge periods: start with period=0 → done pulse next cycle, busy never 1. Start with period=1 and en=1 → busy 1 cycle, done on the following cycle. Start with period=255 → 255 enabled cycles to done.
- Reset mid-operation: rst asserted while cnt=3 in RUN with start also high → next cycle cnt=0, busy=0, done=0. The first start after reset behaves as in the one-shot scenario.
